// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing constants and helpers for the VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FRONT,
        REG_SYNC,
        REG_BACK
    } region_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;

    function automatic int h_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic region_e region_of(int cnt, int act, int fp, int sync);
        if (cnt < act) begin
            return REG_ACTIVE;
        end else if (cnt < act + fp) begin
            return REG_FRONT;
        end else if (cnt < act + fp + sync) begin
            return REG_SYNC;
        end else begin
            return REG_BACK;
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered region and sync level.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACT  = DEF_H_ACTIVE,
    parameter int   FP   = DEF_H_FP,
    parameter int   SYNC = DEF_H_SYNC,
    parameter int   BP   = DEF_H_BP,
    parameter logic POL  = 1'b0,
    localparam int  TOTAL = h_total(ACT, FP, SYNC, BP),
    localparam int  W     = $clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic [1:0]   region_o,
    output logic         sync_o
);

    logic [W-1:0] cnt_q, cnt_d;
    region_e      region_q, region_d;
    logic         sync_q, sync_d;

    // High while the next increment will wrap the count back to 0.
    assign wrap_o = (cnt_q == W'(TOTAL - 1));

    // Region and sync are decoded from the next count so they land on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
        region_d = region_of(int'(cnt_d), ACT, FP, SYNC);
        sync_d   = (region_d == REG_SYNC) ? POL : ~POL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= W'(TOTAL - 1);
            region_q <= REG_BACK;
            sync_q   <= ~POL;
        end else begin
            cnt_q    <= cnt_d;
            region_q <= region_d;
            sync_q   <= sync_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign region_o = region_q;
    assign sync_o   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel-rate divider, h/v counters, syncs, data enable, strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    localparam int  H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  XW        = $clog2(H_TOTAL),
    localparam int  YW        = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic          pix_en_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          de_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          line_start_o,
    output logic          frame_start_o
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: every active/porch/sync value and CLK_DIV must be >= 1");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          h_wrap, v_wrap, v_inc;
    logic [1:0]    h_region, v_region;
    logic          pix_en_q, line_start_q, frame_start_q;

    // With CLK_DIV=1 the divider never leaves 0, so tick follows enable_i.
    assign tick = enable_i && (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        if (enable_i) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    assign v_inc = tick && h_wrap;

    vga_axis_counter #(
        .ACT  (H_ACTIVE),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .POL  (HSYNC_POL)
    ) u_h_axis (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (tick),
        .cnt_o    (x_o),
        .wrap_o   (h_wrap),
        .region_o (h_region),
        .sync_o   (hsync_o)
    );

    vga_axis_counter #(
        .ACT  (V_ACTIVE),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .POL  (VSYNC_POL)
    ) u_v_axis (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (v_inc),
        .cnt_o    (y_o),
        .wrap_o   (v_wrap),
        .region_o (v_region),
        .sync_o   (vsync_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= tick;
            line_start_q  <= v_inc;
            frame_start_q <= v_inc && v_wrap;
        end
    end

    // Both regions are flops, so de_o only moves on the counter edge.
    assign de_o          = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    assign pix_en_o      = pix_en_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. It replaces the fixed 640x480 clock_divider plus horizontal/vertical counter/state-machine cluster with one configurable block.
- Generates a pixel-rate enable, h/v position counters, hsync/vsync with selectable polarity, a data-enable signal, and line/frame start strobes.
- Pixel sources (logo LUTs, pattern generators) consume x_o/y_o/de_o; the top level gates RGB with de_o.

Parameters:
- H_ACTIVE, 640, visible pixels per line (>=1)
- H_FP, 16, horizontal front porch in pixels (>=1)
- H_SYNC, 96, hsync width in pixels (>=1)
- H_BP, 48, horizontal back porch in pixels (>=1)
- V_ACTIVE, 480, visible lines per frame (>=1)
- V_FP, 10, vertical front porch in lines (>=1)
- V_SYNC, 2, vsync width in lines (>=1)
- V_BP, 33, vertical back porch in lines (>=1)
- HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync_o
- CLK_DIV, 2, clk_i cycles per pixel (>=1)
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)

Ports:
- clk_i  in  1  system clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  run enable; low freezes all state
- pix_en_o  out  1  one-clk pulse in the cycle the outputs hold a new pixel
- x_o  out  XW  horizontal count, 0..H_TOTAL-1
- y_o  out  YW  vertical count, 0..V_TOTAL-1
- de_o  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync_o  out  1  horizontal sync at HSYNC_POL level when asserted
- vsync_o  out  1  vertical sync at VSYNC_POL level when asserted
- line_start_o  out  1  one-clk strobe, x_o becomes 0
- frame_start_o  out  1  one-clk strobe, x_o and y_o both become 0

Behaviour:
- Divider: div counter 0..CLK_DIV-1, advances on every clk while enable_i=1. tick = enable_i && div==CLK_DIV-1. With CLK_DIV=1, tick=enable_i.
- On tick, hcnt increments. At H_TOTAL-1 it wraps to 0 and raises h_wrap. On h_wrap, vcnt increments and wraps at V_TOTAL-1 to 0.
- Per-axis region FSM, decoded from the counter: ACTIVE [0, ACT-1], FRONT [ACT, ACT+FP-1], SYNC [ACT+FP, ACT+FP+SYNC-1], BACK [remainder]. Transitions happen only on the axis's increment.
- All outputs are registered and update on the same edge as the counters (zero added latency vs counter). Only that edge changes them.
- hsync_o = HSYNC_POL in h SYNC region, else ~HSYNC_POL. vsync_o follows the v region only, so it changes only at x=0.
- pix_en_o = registered tick. line_start_o = tick && new hcnt==0. frame_start_o = line_start && new vcnt==0. All strobes are exactly 1 clk wide.
- Reset (async assert, sync deassert handled upstream) sets:
  - hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, div=0
  - x_o/y_o = those values
  - de_o=0, hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL
  - all strobes 0
- The first tick after reset therefore lands on (0,0) with frame_start_o=1.
- enable_i=0: div, counters and levels hold; strobes and pix_en_o are 0 the next cycle. Deassertion mid-line resumes exactly where the count stopped.
- Reset mid-frame: immediate return to reset values; no partial strobes.
- Elaboration: $error if any porch/sync/active value <1 or CLK_DIV<1.

Decomposition:
- Package vga_timing_pkg:
  - region enum {REG_ACTIVE, REG_FRONT, REG_SYNC, REG_BACK}
  - 640x480@60 default constants
  - H_TOTAL/V_TOTAL helper functions
- Sub-module vga_axis_counter (params ACT/FP/SYNC/BP/POL; ports clk_i, rst_ni, inc_i, cnt_o, wrap_o, region_o, sync_o). Instantiated twice: the h instance is driven by tick; the v instance by tick&&h_wrap.

Test Plan:
All scenarios use small params H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), CLK_DIV=2, POL=0 unless noted.
1. Release rst_ni with enable_i=1 -> on 2nd clk: pix_en_o=1, x_o=0, y_o=0, de_o=1, line_start_o=1, frame_start_o=1; before that de_o=0, hsync_o=vsync_o=1.
2. Run one line -> de_o high for x 0..7, hsync_o=0 exactly for x 10..12, line_start_o period 28 clk, pix_en_o every 2nd clk.
3. Run two frames -> vsync_o=0 for y 5..6 only, changes coincide with line_start_o; frame_start_o period 224 clk; de_o=0 for y>=4.
4. enable_i=0 for 10 clk while x_o=5 -> x_o holds 5, pix_en_o/strobes 0; after re-enable the next pix_en_o shows x_o=6, timing otherwise unshifted.
5. Assert rst_ni at x=9, y=3 -> same cycle x_o=13, y_o=7, de_o=0, syncs inactive; after release, the sequence matches scenario 1.
6. HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1 -> pix_en_o constant high, x_o advances every clk, hsync_o=1 only for x 10..12, vsync_o=1 only for y 5..6.
